// File: rtl/subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding for the start/busy/done handshake FSM.
package subtractor_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;

  localparam int DEFAULT_NUM_BITS = 16;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor: diff = a - b - borrow_in, purely combinational.
// Zero latency; no handshake.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial a - b - borrow_in, LSB first; NUM_BITS edges from accepted start to done.
// start is ignored while busy; results are held until the next completion.
module serial_subtractor_16bit
  import subtractor_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
);

  localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  sub_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] a_sr_q, a_sr_d;
  logic [NUM_BITS-1:0] b_sr_q, b_sr_d;
  logic [NUM_BITS-1:0] res_q, res_d;
  logic                br_q, br_d;
  logic [NUM_BITS-1:0] diff_q, diff_d;
  logic                uf_q, uf_d;

  logic                bit_diff;
  logic                bit_borrow;
  logic [NUM_BITS-1:0] res_shifted;

  full_subtractor_1bit u_fs (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .borrow_in  (br_q),
    .diff       (bit_diff),
    .borrow_out (bit_borrow)
  );

  // Each new bit enters at the MSB so after NUM_BITS shifts bit 0 sits at the LSB.
  assign res_shifted = {bit_diff, res_q[NUM_BITS-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    uf_d    = uf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        res_d  = res_shifted;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = bit_borrow;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = res_shifted;
          uf_d    = bit_borrow;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      uf_q    <= uf_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign underflow = uf_q;

endmodule
